lcd_frame_scheduler: RTL
========================

// Module: lcd_frame_scheduler
// PURPOSE
//  Shares the 2x16 character LCD between NUM_REQ requesters (status, debug, alarm, UART echo).
//  Each requester offers one 16-char line and a target line. The block grants round-robin
//  and writes the winner into a 256-bit frame register. It holds each message a minimum
//  dwell time. chars feeds the LCD driver's chars input; the driver samples it once per refresh.
// PARAMETERS
//  NUM_REQ       4           number of requesters, 2..8
//  DWELL_CYCLES  50_000_000  min clk cycles a granted message stays before the next grant (1 s @ 50 MHz)
//  CNT_W         26          dwell counter width; must hold DWELL_CYCLES-1
// PORTS
//  clk        in   1            system clock, single clock domain
//  rst_n      in   1            asynchronous active-low reset
//  req        in   NUM_REQ      level request per requester; held until gnt
//  line_sel   in   NUM_REQ      per requester target line: 0 = top, 1 = bottom
//  msg_data   in   NUM_REQ*128  requester i line in [i*128+:128]; 8-bit ASCII, first char in MSB byte
//  gnt        out  NUM_REQ      one-hot, one-cycle pulse: message consumed
//  chars      out  256          frame: top line [255:128], bottom line [127:0], first char MSB
//  busy       out  1            high while in LOAD or DWELL
//  owner      out  3            index of last granted requester
// BEHAVIOUR
//  Reset (async, rst_n=0): chars = 32 x 8'h20 (spaces), gnt = 0, busy = 0, owner = 0,
//   rr_ptr = NUM_REQ-1 (requester 0 wins first), dwell counter = 0, state = IDLE.
//  FSM: IDLE -> LOAD -> DWELL -> IDLE.
//   IDLE: if |req, latch winner = first set req scanning rr_ptr+1 .. rr_ptr (mod NUM_REQ); go LOAD.
//   LOAD (1 cycle): gnt[winner]=1. Write msg_data[winner] into the line selected by
//    line_sel[winner]; the other line is unchanged. rr_ptr <= winner; owner <= winner;
//    counter <= DWELL_CYCLES-1; go DWELL.
//   DWELL: counter decrements each cycle. At 0 go IDLE. req is ignored (no grant) during DWELL.
//  Latency: req rises at edge t (state IDLE). gnt high in cycle t+1. chars updated at edge t+2.
//  Back-to-back: a continuously pending request is granted DWELL_CYCLES+2 cycles after the previous grant.
//  Data sampled only in the LOAD cycle. Requester drops req after gnt. req still high the
//   cycle after gnt is a new request.
//  Simultaneous requests: strict round-robin, no starvation. Max wait (NUM_REQ-1)*(DWELL_CYCLES+2).
//  req withdrawn before grant: not granted, no frame change.
//  Reset mid-DWELL or mid-LOAD: immediate return to reset values; a pending gnt is lost.
//  DWELL_CYCLES = 1 is legal: DWELL lasts one cycle.
//  chars changes only in LOAD. All outputs are registered.
// CONFIGURATION
//  LCD_PREEMPT_EN defined: requester 0 is the alarm requester. req[0] in DWELL while owner != 0
//   aborts the dwell: next cycle IDLE, and req[0] wins regardless of rr_ptr.
//   A dwell owned by requester 0 is never preempted.
//  LCD_PREEMPT_EN undefined: DWELL is never aborted; requester 0 is an ordinary round-robin peer.
// STRUCTURE
//  Package lcd_pkg: CHAR_W=8, LINE_CHARS=16, LINE_W=128, FRAME_W=256,
//   BLANK_LINE = {16{8'h20}}, FSM state encoding (IDLE, LOAD, DWELL).
//  Sub-module rr_arbiter (NUM_REQ param): inputs req and rr_ptr; outputs one-hot winner and index.
//   Combinational. Reused by future bus sharers.
//  Top: FSM, dwell counter, frame register, line write mux.
// TESTING
//  1. After reset, no req -> chars = 256'h2020..20, gnt = 0, busy = 0 indefinitely.
//  2. req[2]=1, line_sel[2]=1, msg "TEMP 25C        " -> gnt[2] one pulse at t+1.
//     chars[127:0] = msg at t+2; chars[255:128] stays spaces.
//  3. req = 4'b1111 held, DWELL_CYCLES=10 -> grants 0,1,2,3,0 at 12-cycle spacing.
//  4. Grant to 1, then assert rst_n=0 at DWELL count 5 -> chars back to spaces, busy = 0.
//     After release, req[1] is granted before req[3].
//  5. LCD_PREEMPT_EN defined: owner = 2 in DWELL, pulse req[0] -> gnt[0] within 2 cycles.
//     Undefined: gnt[0] only after dwell expiry.
//  6. Requests 1 and 3 both on line 0, 2 on line 1 -> top line shows the last line-0 grantee.
//     Bottom line is unaffected by line-0 writes.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the LCD frame scheduler.
// Optional alarm preemption is selected in the top with the LCD_PREEMPT_EN macro.
package lcd_pkg;

  localparam int CHAR_W     = 8;
  localparam int LINE_CHARS = 16;
  localparam int LINE_W     = CHAR_W * LINE_CHARS;
  localparam int FRAME_W    = 2 * LINE_W;
  localparam int OWNER_W    = 3;

  localparam logic [CHAR_W-1:0] SPACE_CHAR = 8'h20;
  localparam logic [LINE_W-1:0] BLANK_LINE = {LINE_CHARS{SPACE_CHAR}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DWELL = 2'd2
  } state_e;

endpackage : lcd_pkg

// File: rtl/lcd_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request after rr_ptr_i,
// wrapping modulo NUM_REQ, so the requester named by rr_ptr_i has lowest priority.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // NOTE: every output gets a default before the search loop, so no path
  // through this block can leave a value held over and infer a latch.
  always_comb begin
    winner_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!valid_o && req_i[i] && (((int'(rr_ptr_i) + k) % NUM_REQ) == i)) begin
          winner_o[i] = 1'b1;
          idx_o       = IDX_W'(i);
          valid_o     = 1'b1;
        end
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/lcd_frame_scheduler.sv
// Round-robin sharer of a 2x16 LCD frame with a minimum per-message dwell time.
// Define LCD_PREEMPT_EN to let requester 0 (alarm) abort another requester's dwell.
module lcd_frame_scheduler
  import lcd_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        line_sel,
  input  logic [NUM_REQ*LINE_W-1:0] msg_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [FRAME_W-1:0]        chars,
  output logic                      busy,
  output logic [OWNER_W-1:0]        owner
);

  localparam logic [CNT_W-1:0]   DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [OWNER_W-1:0] LAST_REQ     = OWNER_W'(NUM_REQ - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [OWNER_W-1:0]   rr_ptr_q;
  logic [OWNER_W-1:0]   owner_q;
  logic [OWNER_W-1:0]   win_idx_q;
  logic [NUM_REQ-1:0]   win_oh_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [FRAME_W-1:0]   chars_q;
  logic                 busy_q;

  logic [OWNER_W-1:0]   arb_ptr;
  logic [NUM_REQ-1:0]   arb_oh;
  logic [OWNER_W-1:0]   arb_idx;
  logic                 arb_valid;
  logic [LINE_W-1:0]    load_line;
  logic                 load_bottom;
  logic [FRAME_W-1:0]   chars_d;

`ifdef LCD_PREEMPT_EN
  logic preempt_q;

  // After an abort, pointing the arbiter at the last slot makes requester 0 scan first.
  assign arb_ptr = (preempt_q && req[0]) ? LAST_REQ : rr_ptr_q;
`else
  assign arb_ptr = rr_ptr_q;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OWNER_W)
  ) u_arb (
    .req_i    (req),
    .rr_ptr_i (arb_ptr),
    .winner_o (arb_oh),
    .idx_o    (arb_idx),
    .valid_o  (arb_valid)
  );

  // Line write mux: the latched winner's message replaces exactly one half of the frame.
  always_comb begin
    load_line   = BLANK_LINE;
    load_bottom = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh_q[i]) begin
        load_line   = msg_data[i*LINE_W +: LINE_W];
        load_bottom = line_sel[i];
      end
    end
    chars_d = chars_q;
    if (load_bottom) chars_d[LINE_W-1:0]       = load_line;
    else             chars_d[FRAME_W-1:LINE_W] = load_line;
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rr_ptr_q  <= LAST_REQ;
      owner_q   <= '0;
      win_idx_q <= '0;
      win_oh_q  <= '0;
      gnt_q     <= '0;
      chars_q   <= {2{BLANK_LINE}};
      busy_q    <= 1'b0;
`ifdef LCD_PREEMPT_EN
      preempt_q <= 1'b0;
`endif
    end else begin
      gnt_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            win_oh_q  <= arb_oh;
            win_idx_q <= arb_idx;
            gnt_q     <= arb_oh;
            busy_q    <= 1'b1;
            state_q   <= ST_LOAD;
`ifdef LCD_PREEMPT_EN
            preempt_q <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          chars_q  <= chars_d;
          rr_ptr_q <= win_idx_q;
          owner_q  <= win_idx_q;
          cnt_q    <= DWELL_RELOAD;
          state_q  <= ST_DWELL;
        end
        ST_DWELL: begin
`ifdef LCD_PREEMPT_EN
          if (req[0] && (owner_q != '0)) begin
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else
`endif
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign chars = chars_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule : lcd_frame_scheduler
